dmem_latency: RTL and testbench

Parametrised multi-cycle data memory for the pipelined MIPS core's MEM stage. It replaces the single-cycle data memory with one of configurable width, depth and access latency. A stall output freezes the pipeline while an access is in flight. The block adds byte-enable writes, a response strobe and a completed-access counter. The storage array is named `RAM` and is word-indexed, so benches can preload it with `$readmemh` and dump it hierarchically.

---
 rtl/dmem_latency_if.sv | 31 +++
 rtl/dmem_latency.sv | 150 +++++++++++++++
 tb/tb_dmem_latency.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_latency_if.sv
`default_nettype none
// ============================================================================
// dmem_latency_if : MEM-stage request/response bundle for dmem_latency
// Revision 1.0
// ============================================================================
interface dmem_latency_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic                  req_valid;
   logic                  req_we;
   logic [DATA_W/8-1:0]   req_be;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  stall;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [CNT_W-1:0]      acc_count;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_wdata,
      input  stall, rsp_valid, rsp_rdata, acc_count
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_wdata,
      output stall, rsp_valid, rsp_rdata, acc_count
   );
endinterface
`default_nettype wire

// File: rtl/dmem_latency.sv
`default_nettype none
// ============================================================================
// dmem_latency : multi-cycle byte-enable data memory with stall and counter
// Revision 1.0
// ============================================================================
module dmem_latency #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 16
) (
   input  wire logic       CLK,
   input  wire logic       CLR,
   dmem_latency_if.slave   bus
);

   localparam int NB       = DATA_W / 8;
   localparam int IDX_W    = $clog2(DEPTH);
   localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int CNT_LOAD = (LATENCY >= 2) ? (LATENCY - 2) : 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                commit;
   logic                stall_c;
   logic                rsp_valid_c;

   logic                lat_we;
   logic [NB-1:0]       lat_be;
   logic [IDX_W-1:0]    lat_idx;
   logic [DATA_W-1:0]   lat_wdata;

   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [CNT_W-1:0]    acc_count_q;

   logic [DATA_W-1:0]   RAM [DEPTH];

   logic [IDX_W-1:0]    req_idx;
   logic                use_live;
   logic                com_we;
   logic [NB-1:0]       com_be;
   logic [IDX_W-1:0]    com_idx;
   logic [DATA_W-1:0]   com_wdata;
   logic                unused_addr;

   assign req_idx     = bus.req_addr[IDX_W+1:2];
   assign unused_addr = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[1:0]};

   // With LATENCY=1 the commit edge is also the sampling edge, so the live
   // request fields feed the memory directly instead of the latched copy.
   assign use_live  = (state == IDLE);
   assign com_we    = use_live ? bus.req_we    : lat_we;
   assign com_be    = use_live ? bus.req_be    : lat_be;
   assign com_idx   = use_live ? req_idx       : lat_idx;
   assign com_wdata = use_live ? bus.req_wdata : lat_wdata;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      commit      = 1'b0;
      stall_c     = 1'b0;
      rsp_valid_c = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               stall_c = 1'b1;
               if (LATENCY == 1) begin
                  state_nxt = DONE;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CW'(CNT_LOAD);
               end
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (cnt == '0) begin
               state_nxt = DONE;
               commit    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: begin
            rsp_valid_c = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM sits in the reset process only so that no write can occur while
   // CLR is low; its contents are deliberately left out of the reset branch.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         lat_we      <= 1'b0;
         lat_be      <= '0;
         lat_idx     <= '0;
         lat_wdata   <= '0;
         rsp_rdata_q <= '0;
         acc_count_q <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_be    <= bus.req_be;
            lat_idx   <= req_idx;
            lat_wdata <= bus.req_wdata;
         end
         if (commit) begin
            if (com_we) begin
               for (int i = 0; i < NB; i++) begin
                  if (com_be[i]) begin
                     RAM[com_idx][i*8 +: 8] <= com_wdata[i*8 +: 8];
                  end
               end
            end else begin
               rsp_rdata_q <= RAM[com_idx];
            end
            if (acc_count_q != '1) begin
               acc_count_q <= acc_count_q + 1'b1;
            end
         end
      end
   end

   assign bus.stall     = stall_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.acc_count = acc_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_latency.sv
`default_nettype none
// ============================================================================
// tb_dmem_latency : scoreboard bench for dmem_latency (LATENCY 4 and 1)
// Revision 1.0
// ============================================================================
module tb_dmem_latency;

   logic clk;
   logic clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] cnt;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   exp_t e4, e1;
   int   cnt_m [2];

   dmem_latency_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) bus4 ();
   dmem_latency_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(2))  bus1 ();

   dmem_latency #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(4), .CNT_W(16)) u_dut4 (
      .CLK (clk),
      .CLR (clr),
      .bus (bus4)
   );

   dmem_latency #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1), .CNT_W(2)) u_dut1 (
      .CLK (clk),
      .CLR (clr),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel == 1) begin
         bus1.req_valid = v; bus1.req_we = we; bus1.req_be = be;
         bus1.req_addr  = a; bus1.req_wdata = d;
      end else begin
         bus4.req_valid = v; bus4.req_we = we; bus4.req_be = be;
         bus4.req_addr  = a; bus4.req_wdata = d;
      end
   endtask

   function automatic logic get_stall(input int sel);
      return (sel == 1) ? bus1.stall : bus4.stall;
   endfunction

   function automatic logic get_rv(input int sel);
      return (sel == 1) ? bus1.rsp_valid : bus4.rsp_valid;
   endfunction

   // One access: push the expected response, then measure stall length.
   task automatic access(input int sel, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      int n;
      int lat;
      exp_t e;
      lat = (sel == 1) ? 1 : 4;
      if (cnt_m[sel] < ((sel == 1) ? 3 : 65535)) cnt_m[sel]++;
      e.rd  = exp_rd;
      e.cnt = cnt_m[sel];
      if (sel == 1) q1.push_back(e); else q4.push_back(e);
      @(negedge clk);
      drive(sel, 1'b1, we, be, a, d);
      #1;
      n = 0;
      while (get_stall(sel) && n < 20) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk((sel == 1) ? "stall_cycles_l1" : "stall_cycles_l4", n, lat);
      chk((sel == 1) ? "rsp_valid_l1" : "rsp_valid_l4", {31'd0, get_rv(sel)}, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
   endtask

   always @(negedge clk) begin
      if (bus4.rsp_valid) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb4_unexpected actual=rsp_valid required=no_response");
         end else begin
            e4 = q4.pop_front();
            chk("rdata_l4", bus4.rsp_rdata, e4.rd);
            chk("count_l4", {16'd0, bus4.acc_count}, e4.cnt);
         end
      end
      if (bus1.rsp_valid) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb1_unexpected actual=rsp_valid required=no_response");
         end else begin
            e1 = q1.pop_front();
            chk("rdata_l1", bus1.rsp_rdata, e1.rd);
            chk("count_l1", {30'd0, bus1.acc_count}, e1.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      clr = 1'b0;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_stall",     {31'd0, bus4.stall},     32'd0);
      chk("reset_rsp_valid", {31'd0, bus4.rsp_valid}, 32'd0);
      chk("reset_rdata",     bus4.rsp_rdata,          32'd0);
      chk("reset_count",     {16'd0, bus4.acc_count}, 32'd0);

      // Preload through the port, then reset and confirm RAM survives.
      access(0, 1'b1, 4'hF, 32'h24, 32'hDEADBEEF, 32'h0);
      access(0, 1'b1, 4'hF, 32'h14, 32'h12345678, 32'h0);
      access(0, 1'b1, 4'hF, 32'h08, 32'hAABBCCDD, 32'h0);
      access(0, 1'b1, 4'hF, 32'h1C, 32'h00000000, 32'h0);
      idle();
      do_reset();
      #1;
      chk("reset2_count", {16'd0, bus4.acc_count}, 32'd0);
      chk("reset2_rdata", bus4.rsp_rdata, 32'd0);
      chk("ram9_kept",    u_dut4.RAM[9], 32'hDEADBEEF);

      access(0, 1'b0, 4'h0, 32'h14, 32'h0, 32'h12345678);
      access(0, 1'b1, 4'h5, 32'h08, 32'h11223344, 32'h12345678);
      idle();
      @(negedge clk);
      chk("ram2_byte_en", u_dut4.RAM[2], 32'hAA22CC44);
      access(0, 1'b0, 4'h0, 32'h08, 32'h0, 32'hAA22CC44);
      access(0, 1'b0, 4'h0, 32'h0B, 32'h0, 32'hAA22CC44);
      access(0, 1'b0, 4'h0, 32'h414, 32'h0, 32'h12345678);
      idle();

      // Reset in the second WAIT cycle of a store.
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 4'hF, 32'h1C, 32'hFFFFFFFF);
      @(negedge clk);
      @(negedge clk);
      #1;
      clr = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("midrst_stall",     {31'd0, bus4.stall},     32'd0);
      chk("midrst_count",     {16'd0, bus4.acc_count}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, bus4.rsp_valid}, 32'd0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      @(negedge clk);
      chk("ram7_untouched", u_dut4.RAM[7], 32'h0);
      access(0, 1'b0, 4'h0, 32'h1C, 32'h0, 32'h0);
      idle();

      // LATENCY=1 instance: wrap, back-to-back, counter saturation at 3.
      access(1, 1'b1, 4'hF, 32'h400, 32'h55, 32'h0);
      access(1, 1'b0, 4'h0, 32'h000, 32'h0, 32'h55);
      chk("l1_ram0_wrap", u_dut1.RAM[0], 32'h55);
      access(1, 1'b0, 4'h0, 32'h400, 32'h0, 32'h55);
      access(1, 1'b1, 4'hF, 32'h004, 32'h0000ABCD, 32'h55);
      access(1, 1'b0, 4'h0, 32'h004, 32'h0, 32'h0000ABCD);
      idle();
      repeat (3) @(negedge clk);
      #1;
      chk("l1_sat_count", {30'd0, bus1.acc_count}, 32'd3);
      chk("l4_queue_empty", q4.size(), 32'd0);
      chk("l1_queue_empty", q1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
